htif_in_arbiter: RTL

Packet-granular arbiter that shares the chip's narrow HTIF input channel between host-side traffic and memory-backup responses. Backup responses cannot be backpressured, so they land in an internal FIFO and are forwarded only as whole bursts. Host packets are never interleaved with backup beats. The block sits in the test harness between the host tick source, the backup-memory deserializer and the DUT's `io_host_in` port, replacing the combinational priority mux.

---
 rtl/htif_in_arbiter_if.sv | 24 ++
 rtl/htif_in_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/htif_in_arbiter_if.sv
// Handshake bundle between host source, backup deserializer and the DUT's HTIF input.
// slave is the arbiter's view; master is the view of whatever drives it.
interface htif_in_arbiter_if #(parameter int W = 16);
  logic         host_valid;
  logic         host_ready;
  logic [W-1:0] host_bits;
  logic         host_last;
  logic         bk_valid;
  logic [W-1:0] bk_bits;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bits;
  logic         out_src;

  modport slave (
    input  host_valid, host_bits, host_last, bk_valid, bk_bits, out_ready,
    output host_ready, out_valid, out_bits, out_src
  );

  modport master (
    output host_valid, host_bits, host_last, bk_valid, bk_bits, out_ready,
    input  host_ready, out_valid, out_bits, out_src
  );
endinterface

// File: rtl/htif_in_arbiter.sv
// Packet-granular arbiter for the HTIF input channel: host packets vs. whole
// backup bursts buffered in an unstallable FIFO.
module htif_in_arbiter #(
  parameter  int W        = 16,
  parameter  int DEPTH    = 16,
  parameter  int BK_BEATS = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic              htif_clk,
  input  logic              reset,
  htif_in_arbiter_if.slave  io,
  output logic [LW-1:0]     bk_level,
  output logic              overflow
);
  localparam int CW = $clog2(BK_BEATS + 1);

  typedef enum logic [1:0] {IDLE, HOST, BK} state_e;

  state_e        state_q, state_d;
  logic          last_bk_q, last_bk_d;   // last grant went to backup
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pend_q, pend_d;
  logic [CW-1:0] wcnt_q, wcnt_d, dcnt_q, dcnt_d;
  logic          ovf_q, ovf_d;

  logic full, rd_en, wr_en, burst_in, burst_out, pend, urgent;

  // FIFO and burst bookkeeping
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    rd_en     = (state_q == BK) && io.out_ready;
    wr_en     = io.bk_valid && (!full || rd_en);
    burst_in  = wr_en && (wcnt_q == CW'(BK_BEATS - 1));
    burst_out = rd_en && (dcnt_q == CW'(BK_BEATS - 1));
    pend      = (pend_q != '0);
    urgent    = pend && (level_q > LW'(DEPTH - BK_BEATS));

    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(rd_en);
    level_d   = level_q + LW'(wr_en) - LW'(rd_en);
    pend_d    = pend_q + LW'(burst_in) - LW'(burst_out);
    ovf_d     = ovf_q | (io.bk_valid && !wr_en);
    wcnt_d    = wr_en ? (burst_in  ? '0 : wcnt_q + CW'(1)) : wcnt_q;
    dcnt_d    = rd_en ? (burst_out ? '0 : dcnt_q + CW'(1)) : dcnt_q;
  end

  // Grant decision and output mux
  always_comb begin
    state_d       = state_q;
    last_bk_d     = last_bk_q;
    io.out_valid  = 1'b0;
    io.host_ready = 1'b0;
    io.out_bits   = '0;
    io.out_src    = 1'b0;
    case (state_q)
      IDLE: begin
        if (urgent || (pend && io.host_valid && !last_bk_q)) begin
          state_d   = BK;
          last_bk_d = 1'b1;
        end else if (io.host_valid) begin
          state_d   = HOST;
          last_bk_d = 1'b0;
        end else if (pend) begin
          state_d   = BK;
          last_bk_d = 1'b1;
        end
      end
      HOST: begin
        io.out_valid  = io.host_valid;
        io.out_bits   = io.host_bits;
        io.host_ready = io.out_ready;
        if (io.host_valid && io.out_ready && io.host_last) state_d = IDLE;
      end
      BK: begin
        io.out_valid = 1'b1;
        io.out_bits  = mem_q[rd_ptr_q];
        io.out_src   = 1'b1;
        if (burst_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge htif_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_bk_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pend_q    <= '0;
      wcnt_q    <= '0;
      dcnt_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_bk_q <= last_bk_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pend_q    <= pend_d;
      wcnt_q    <= wcnt_d;
      dcnt_q    <= dcnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the cleared pointers make stale entries unreachable.
  always_ff @(posedge htif_clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= io.bk_bits;
  end

  assign bk_level = level_q;
  assign overflow = ovf_q;
endmodule
